// File: rtl/boid_update_sched.sv
// Pass scheduler for the boid update datapath: walks every boid as "self", reads each neighbour,
// strobes the pairwise accumulator and writes the result back. Optional macro BOID_SCHED_SKIP_SELF_EN.
module boid_update_sched #(
    parameter  int NUM_BOIDS = 2,
    localparam int IW        = (NUM_BOIDS > 1) ? $clog2(NUM_BOIDS) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic          rd_valid,
    output logic [IW-1:0] which_boid,
    output logic [IW-1:0] other_boid,
    output logic          rd_self,
    output logic          rd_other,
    output logic          acc_clr,
    output logic          acc_en,
    output logic [6:0]    w_en,
    output logic          busy,
    output logic          done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELF_RD,
        S_SELF_WAIT,
        S_PAIR_RD,
        S_PAIR_WAIT,
        S_PAIR_CALC,
        S_WB
    } state_t;

    localparam logic [IW-1:0] LAST    = IW'(NUM_BOIDS - 1);
    localparam logic [6:0]    WB_MASK = 7'b0011111;

    state_t        state_q, state_d;
    logic [IW-1:0] i_q, i_d;
    logic [IW-1:0] j_q, j_d;
    logic          en_q;
    logic          pending_q, pending_d;
    logic          start;

    logic [IW-1:0] first_nb;
    logic [IW-1:0] next_nb;
    logic          last_nb;

    assign start = en_q & ~en;

`ifdef BOID_SCHED_SKIP_SELF_EN
    // Neighbour set excludes j == i: step over the self index when walking j.
    logic [IW-1:0] inc_j;
    always_comb begin
        inc_j    = j_q + IW'(1);
        first_nb = (i_q == '0) ? IW'(1) : '0;
        next_nb  = (inc_j == i_q) ? (j_q + IW'(2)) : inc_j;
        last_nb  = (j_q == LAST) || ((i_q == LAST) && (j_q == (LAST - IW'(1))));
    end
`else
    // Every j is visited, including j == i; the datapath masks the self pair.
    always_comb begin
        first_nb = '0;
        next_nb  = j_q + IW'(1);
        last_nb  = (j_q == LAST);
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            i_q       <= '0;
            j_q       <= '0;
            en_q      <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            i_q       <= i_d;
            j_q       <= j_d;
            en_q      <= en;
            pending_q <= pending_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        i_d       = i_q;
        j_d       = j_q;
        pending_d = pending_q;

        // A request arriving mid-pass is remembered once; IDLE always consumes it.
        if (state_q == S_IDLE) begin
            pending_d = 1'b0;
        end else if (start) begin
            pending_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (start || pending_q) begin
                    i_d     = '0;
                    j_d     = '0;
                    state_d = S_SELF_RD;
                end
            end
            S_SELF_RD: begin
                j_d     = first_nb;
                state_d = S_SELF_WAIT;
            end
            S_SELF_WAIT: begin
                if (rd_valid) begin
                    state_d = S_PAIR_RD;
                end
            end
            S_PAIR_RD: begin
                state_d = S_PAIR_WAIT;
            end
            S_PAIR_WAIT: begin
                if (rd_valid) begin
                    state_d = S_PAIR_CALC;
                end
            end
            S_PAIR_CALC: begin
                if (last_nb) begin
                    state_d = S_WB;
                end else begin
                    j_d     = next_nb;
                    state_d = S_PAIR_RD;
                end
            end
            S_WB: begin
                if (i_q == LAST) begin
                    state_d = S_IDLE;
                end else begin
                    i_d     = i_q + IW'(1);
                    state_d = S_SELF_RD;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Strobes decode straight from the registered state, so they are glitch-free and
    // drop to zero on the edge that applies reset.
    always_comb begin
        rd_self  = (state_q == S_SELF_RD);
        acc_clr  = (state_q == S_SELF_RD);
        rd_other = (state_q == S_PAIR_RD);
        acc_en   = (state_q == S_PAIR_CALC);
        w_en     = (state_q == S_WB) ? WB_MASK : 7'b0000000;
        busy     = (state_q != S_IDLE);
        done     = (state_q == S_WB) && (i_q == LAST);
    end

    assign which_boid = i_q;
    assign other_boid = j_q;

endmodule

// File: tb/tb_boid_update_sched.sv
// Self-checking bench for boid_update_sched: a pair-list model plus a per-cycle monitor,
// with a memory responder returning rd_valid one cycle after each request.
`timescale 1ns/1ps
module tb_boid_update_sched;

    localparam int NB = 3;
    localparam int IW = $clog2(NB);
`ifdef BOID_SCHED_SKIP_SELF_EN
    localparam int PAIRS_LIT = 6;
    localparam int LEN_LIT   = 27;
`else
    localparam int PAIRS_LIT = 9;
    localparam int LEN_LIT   = 36;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          en = 1'b0;
    logic          rd_valid = 1'b0;
    logic [IW-1:0] which_boid, other_boid;
    logic          rd_self, rd_other, acc_clr, acc_en, busy, done;
    logic [6:0]    w_en;

    always #5 clk = ~clk;

    boid_update_sched #(.NUM_BOIDS(NB)) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .rd_valid   (rd_valid),
        .which_boid (which_boid),
        .other_boid (other_boid),
        .rd_self    (rd_self),
        .rd_other   (rd_other),
        .acc_clr    (acc_clr),
        .acc_en     (acc_en),
        .w_en       (w_en),
        .busy       (busy),
        .done       (done)
    );

    int n_vec = 0;
    int n_bad = 0;

    function automatic void check(string name, int act, int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Model: ordered list of (self, neighbour) pairs one pass must visit, and the pass length.
    int exp_pi[$];
    int exp_pj[$];
    int pass_len = 0;

    // Memory responder.
    int resp_wait   = -1;
    int stall_next  = 0;
    bit early_valid = 1'b0;
    bit stray_idle  = 1'b0;

    always @(negedge clk) begin
        if (reset) begin
            resp_wait = -1;
        end else if (rd_self) begin
            resp_wait = 0;
        end else if (rd_other) begin
            resp_wait  = stall_next;
            stall_next = 0;
        end
    end

    always @(posedge clk) begin
        #1;
        if (resp_wait == 0) begin
            rd_valid  = 1'b1;
            resp_wait = -1;
        end else begin
            if (resp_wait > 0) resp_wait--;
            rd_valid = stray_idle || (early_valid && rd_other);
        end
    end

    // Per-cycle monitor.
    int acc_idx = 0, wb_idx = 0, done_cnt = 0, busy_len = 0;
    int exp_extra = 0, last_len = 0, last_acc = 0;
    bit in_pair = 1'b0;
    logic [IW-1:0] held_other = '0;

    always @(negedge clk) begin
        if (reset) begin
            acc_idx  = 0;
            wb_idx   = 0;
            busy_len = 0;
            in_pair  = 1'b0;
        end else begin
            check("acc_clr_vs_rd_self", acc_clr, rd_self);
            if (!busy) check("idle_strobes", {rd_self, rd_other, acc_en, done, w_en}, 0);
            if (busy) busy_len++; else busy_len = 0;
            if (rd_self) check("self_rd_index", which_boid, wb_idx);
            if (rd_other) begin
                if (acc_idx < exp_pi.size()) begin
                    check("pair_rd_i", which_boid, exp_pi[acc_idx]);
                    check("pair_rd_j", other_boid, exp_pj[acc_idx]);
                end else begin
                    check("pair_rd_overrun", acc_idx + 1, exp_pi.size());
                end
                held_other = other_boid;
                in_pair    = 1'b1;
            end else if (in_pair && !acc_en) begin
                check("other_stable", other_boid, held_other);
            end
            if (acc_en) begin
                check("acc_after_rd", in_pair, 1);
                if (acc_idx < exp_pi.size()) begin
                    check("acc_i", which_boid, exp_pi[acc_idx]);
                    check("acc_j", other_boid, exp_pj[acc_idx]);
                end else begin
                    check("acc_overrun", acc_idx + 1, exp_pi.size());
                end
                acc_idx++;
                in_pair = 1'b0;
            end
            if (w_en != 7'd0) begin
                check("w_en_value", w_en, 7'b0011111);
                check("wb_index", which_boid, wb_idx);
                wb_idx++;
            end
            if (done) begin
                done_cnt++;
                check("done_in_wb", w_en, 7'b0011111);
                check("done_last_i", which_boid, NB - 1);
                check("pass_pairs", acc_idx, exp_pi.size());
                check("pass_wbs", wb_idx, NB);
                check("pass_len", busy_len, pass_len + exp_extra);
                last_len  = busy_len;
                last_acc  = acc_idx;
                acc_idx   = 0;
                wb_idx    = 0;
                exp_extra = 0;
            end
        end
    end

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_pass();
        en = 1'b1;
        tick(1);
        en = 1'b0;
    endtask

    task automatic wait_done(string name, int limit);
        int k = 0;
        while (k < limit) begin
            @(negedge clk);
            if (done) break;
            k++;
        end
        check({name, "_done_seen"}, int'(k < limit), 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int found;
        for (int i = 0; i < NB; i++) begin
            for (int j = 0; j < NB; j++) begin
`ifdef BOID_SCHED_SKIP_SELF_EN
                if (i == j) continue;
`endif
                exp_pi.push_back(i);
                exp_pj.push_back(j);
            end
        end
        pass_len = NB * (3 + 3 * (exp_pi.size() / NB));

        // Reset state
        tick(3);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_which", which_boid, 0);
        check("rst_other", other_boid, 0);
        check("rst_w_en", w_en, 0);
        check("rst_done", done, 0);
        check("rst_strobes", {rd_self, rd_other, acc_clr, acc_en}, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("no_spurious_start", busy, 0);
        end

        // Basic pass with start latency
        @(posedge clk); #1;
        start_pass();
        @(negedge clk);
        check("start_cycle_t_busy", busy, 0);
        @(negedge clk);
        check("start_t1_busy", busy, 1);
        check("start_t1_rd_self", rd_self, 1);
        wait_done("pass1", 200);
        tick(1);
        check("pass1_len_lit", last_len, LEN_LIT);
        check("pass1_acc_lit", last_acc, PAIRS_LIT);
        check("pass1_done_cnt", done_cnt, 1);

        // First PAIR_WAIT stretched by 5 cycles
        stall_next = 5;
        exp_extra  = 5;
        start_pass();
        wait_done("stall", 200);
        tick(1);
        check("stall_len_lit", last_len, LEN_LIT + 5);
        check("stall_done_cnt", done_cnt, 2);

        // Stray rd_valid while IDLE and during PAIR_RD
        stray_idle = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("stray_idle_busy", busy, 0);
        end
        tick(1);
        stray_idle  = 1'b0;
        early_valid = 1'b1;
        tick(1);
        start_pass();
        wait_done("stray", 200);
        tick(1);
        early_valid = 1'b0;
        check("stray_len_lit", last_len, LEN_LIT);
        check("stray_acc_lit", last_acc, PAIRS_LIT);

        // Two en falling edges during a pass merge into one extra pass
        start_pass();
        tick(4);
        en = 1'b1; tick(1); en = 1'b0; tick(2);
        en = 1'b1; tick(1); en = 1'b0;
        wait_done("dbl_first", 200);
        @(negedge clk);
        check("dbl_idle_gap", busy, 0);
        @(negedge clk);
        check("dbl_restart_busy", busy, 1);
        check("dbl_restart_rd_self", rd_self, 1);
        wait_done("dbl_second", 200);
        repeat (10) begin
            @(negedge clk);
            check("dbl_no_third", busy, 0);
        end
        check("dbl_done_cnt", done_cnt, 5);

        // Start in the same cycle as done sets pending
        @(posedge clk); #1;
        start_pass();
        found = 0;
        for (int k = 0; k < 10 && found == 0; k++) begin
            @(negedge clk);
            if (busy) found = 1;
        end
        check("coinc_busy_seen", found, 1);
        en = 1'b1;
        repeat (pass_len - 1) @(posedge clk);
        #1;
        en = 1'b0;
        @(negedge clk);
        check("coinc_done", done, 1);
        @(negedge clk);
        check("coinc_idle_gap", busy, 0);
        @(negedge clk);
        check("coinc_restart", busy, 1);
        wait_done("coinc_second", 200);
        tick(1);
        check("coinc_done_cnt", done_cnt, 7);

        // Reset during PAIR_CALC of i=1
        start_pass();
        found = 0;
        for (int k = 0; k < 200 && found == 0; k++) begin
            @(negedge clk);
            if (acc_en && which_boid == IW'(1)) found = 1;
        end
        check("abort_point_found", found, 1);
        reset = 1'b1;
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_w_en", w_en, 0);
        check("abort_which", which_boid, 0);
        check("abort_other", other_boid, 0);
        check("abort_acc_en", acc_en, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        tick(1);
        start_pass();
        wait_done("after_abort", 200);
        tick(1);
        check("after_abort_len", last_len, LEN_LIT);
        check("after_abort_acc", last_acc, PAIRS_LIT);
        check("after_abort_done_cnt", done_cnt, 8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
